// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the pipelined binary-to-BCD converter:
// BCD digit type, double-dabble constants and the internal digit-count helper.
package bin2bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    // A digit at or above this value is corrected by adding 3 before the shift
    localparam bcd_digit_t ADD3_THRESH = 4'd5;
    localparam bcd_digit_t ADD3_VAL    = 4'd3;
    // Digit value forced on every output digit when the result does not fit
    localparam bcd_digit_t SAT_DIGIT   = 4'd9;

    // Digits needed to hold any BIN_W-bit magnitude: ceil(bin_w * log10(2)),
    // with log10(2) taken as 0.30103, plus one spare digit so the top digit
    // never receives a carry out of the shift.
    function automatic int bcd_int_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_dabble_stage.sv
// One double-dabble step over N BCD digits: correct every digit >= 5 by
// adding 3, then shift the whole digit vector left by one, taking in the
// next magnitude bit at the LSB. Purely combinational.
module bin2bcd_dabble_stage
    import bin2bcd_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [4*N-1:0] i_dig,
    input  logic           i_bit,
    output logic [4*N-1:0] o_dig
);

    logic [4*N-1:0] w_adj;
    logic           w_unused_top;

    // add-3 correction on each digit ahead of the shift
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < N; k++) begin
            if (bcd_digit_t'(i_dig[4*k +: 4]) >= ADD3_THRESH) begin
                w_adj[4*k +: 4] = i_dig[4*k +: 4] + ADD3_VAL;
            end else begin
                w_adj[4*k +: 4] = i_dig[4*k +: 4];
            end
        end
    end

    assign o_dig = {w_adj[4*N-2:0], i_bit};
    // The digit count leaves headroom, so the bit shifted out is always zero
    assign w_unused_top = w_adj[4*N-1];

endmodule

// File: rtl/bin2bcd_pipe.sv
// Pipelined binary-to-BCD converter with valid/ready handshake.
// Stage 0 registers sign and magnitude; stages 1..BIN_W each apply one
// double-dabble step, so latency is BIN_W+1 cycles at one result per cycle.
// A stalled output freezes the whole pipe. Results wider than DIGITS
// saturate to all nines with bcd_ovf set.
// Build option: define BIN2BCD_SIGNED_EN to treat bin as two's complement;
// otherwise bin is unsigned and the sign bit of bcd is always 0.
module bin2bcd_pipe
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 11,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    bin,
    input  logic                bin_vld,
    output logic                bin_rdy,
    output logic [4*DIGITS:0]   bcd,
    output logic                bcd_ovf,
    output logic                bcd_vld,
    input  logic                bcd_rdy
);

    localparam int ND = bcd_int_digits(BIN_W);
    localparam int DW = 4 * ND;

    logic                        w_stall;
    logic [BIN_W-1:0]            w_mag;
    logic                        w_sign_out;
    logic                        w_ovf;
    logic [4*DIGITS-1:0]         w_digits;
    logic                        w_unused_mag;

    // valid bit per stage, index = stage number
    logic [BIN_W:0]              r_vld_p;
    // remaining magnitude bits, MSB consumed by the following stage
    logic [BIN_W-1:0][BIN_W-1:0] r_mag_p;
    // partial BCD digits after each dabble stage
    logic [BIN_W:1][DW-1:0]      r_dig_p;
    logic [BIN_W:1][DW-1:0]      w_dig_p;

    // Any internal digit at or above DIGITS being non-zero means overflow
    function automatic logic f_ovf(input logic [DW-1:0] d);
        logic ovf;
        ovf = 1'b0;
        for (int i = DIGITS; i < ND; i++) begin
            if (d[4*i +: 4] != 4'd0) ovf = 1'b1;
        end
        return ovf;
    endfunction

    // Saturate to all nines on overflow; digits beyond the internal width read 0
    function automatic logic [4*DIGITS-1:0] f_sat(input logic [DW-1:0] d, input logic ovf);
        logic [4*DIGITS-1:0] res;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf) begin
                res[4*i +: 4] = SAT_DIGIT;
            end else if (i < ND) begin
                res[4*i +: 4] = d[4*(i % ND) +: 4];
            end
        end
        return res;
    endfunction

    assign bcd_vld = r_vld_p[BIN_W];
    assign w_stall = bcd_vld & ~bcd_rdy;
    assign bin_rdy = ~w_stall;

`ifdef BIN2BCD_SIGNED_EN
    logic signed [BIN_W-1:0] w_bin_s;
    logic                    w_sign;
    logic [BIN_W:0]          r_sign_p;

    assign w_bin_s = bin;
    assign w_sign  = w_bin_s[BIN_W-1];
    // Negating in BIN_W bits turns -2^(BIN_W-1) into 2^(BIN_W-1) when read unsigned
    assign w_mag   = w_sign ? $unsigned(-w_bin_s) : $unsigned(w_bin_s);

    // sign rides alongside the data through every stage
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_sign_p <= {r_sign_p[BIN_W-1:0], w_sign};
        end
    end

    assign w_sign_out = r_sign_p[BIN_W];
`else
    assign w_mag      = bin;
    assign w_sign_out = 1'b0;
`endif

    // ---- stage 0 -> stages 1..BIN_W: one dabble step per stage ----
    for (genvar s = 1; s <= BIN_W; s++) begin : g_stage
        logic [DW-1:0] w_dig_in;
        if (s == 1) begin : g_first
            assign w_dig_in = '0;
        end else begin : g_rest
            assign w_dig_in = r_dig_p[s-1];
        end
        bin2bcd_dabble_stage #(.N(ND)) u_stage (
            .i_dig (w_dig_in),
            .i_bit (r_mag_p[s-1][BIN_W-1]),
            .o_dig (w_dig_p[s])
        );
    end

    // stage valid bits: cleared by reset, shifted when the pipe advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
        end else if (!w_stall) begin
            r_vld_p <= {r_vld_p[BIN_W-1:0], bin_vld};
        end
    end

    // data registers advance with the pipe; no reset, outputs are gated by valid
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_mag_p[0] <= w_mag;
            for (int s = 1; s < BIN_W; s++) begin
                r_mag_p[s] <= r_mag_p[s-1] << 1;
            end
            r_dig_p <= w_dig_p;
        end
    end

    // Only the MSB of the last magnitude register is still needed
    assign w_unused_mag = ^r_mag_p[BIN_W-1][BIN_W-2:0];

    // ---- stage BIN_W -> output: overflow detection and saturation ----
    assign w_ovf    = f_ovf(r_dig_p[BIN_W]);
    assign w_digits = f_sat(r_dig_p[BIN_W], w_ovf);
    assign bcd      = bcd_vld ? {w_sign_out, w_digits} : '0;
    assign bcd_ovf  = bcd_vld & w_ovf;

endmodule

// File: tb/tb_bin2bcd_pipe.sv
// Directed bench for bin2bcd_pipe: two instances (DIGITS=4 and DIGITS=3)
// share the same input stream; expected values are hand-computed constants,
// with a decimal model for the incrementing stream.
module tb_bin2bcd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] bin;
    logic        bin_vld;
    logic        bcd_rdy;
    logic        bin_rdy, bcd_ovf, bcd_vld;
    logic [16:0] bcd;
    logic        bin_rdy3, bcd_ovf3, bcd_vld3;
    logic [12:0] bcd3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [16:0] b4;
        logic        o4;
        logic [12:0] b3;
        logic        o3;
    } cap_t;
    cap_t q[$];

`ifdef BIN2BCD_SIGNED_EN
    localparam logic [16:0] E4_N1024 = 17'h11024;
    localparam logic [12:0] E3_N1024 = 13'h1999;
    localparam logic        O3_N1024 = 1'b1;
    localparam logic [16:0] E4_N1    = 17'h10001;
    localparam logic [12:0] E3_N1    = 13'h1001;
    localparam logic        O3_N1    = 1'b0;
    localparam logic [16:0] E4_N999  = 17'h10999;
    localparam logic [12:0] E3_N999  = 13'h1999;
    localparam logic        O3_N999  = 1'b0;
`else
    localparam logic [16:0] E4_N1024 = 17'h01024;
    localparam logic [12:0] E3_N1024 = 13'h0999;
    localparam logic        O3_N1024 = 1'b1;
    localparam logic [16:0] E4_N1    = 17'h02047;
    localparam logic [12:0] E3_N1    = 13'h0999;
    localparam logic        O3_N1    = 1'b1;
    localparam logic [16:0] E4_N999  = 17'h01049;
    localparam logic [12:0] E3_N999  = 13'h0999;
    localparam logic        O3_N999  = 1'b1;
`endif

    bin2bcd_pipe #(.BIN_W(11), .DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .bin(bin), .bin_vld(bin_vld), .bin_rdy(bin_rdy),
        .bcd(bcd), .bcd_ovf(bcd_ovf), .bcd_vld(bcd_vld), .bcd_rdy(bcd_rdy)
    );

    bin2bcd_pipe #(.BIN_W(11), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .bin(bin), .bin_vld(bin_vld), .bin_rdy(bin_rdy3),
        .bcd(bcd3), .bcd_ovf(bcd_ovf3), .bcd_vld(bcd_vld3), .bcd_rdy(bcd_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record every accepted output
    always @(negedge clk) begin
        if (bcd_vld && bcd_rdy) q.push_back('{cyc, bcd, bcd_ovf, bcd3, bcd_ovf3});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m4(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic wait_q(input int n, input int budget);
        for (int i = 0; i < budget && q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int idx;
        int cycles;
        logic [15:0] e;

        rst = 1'b1; bin_vld = 1'b0; bin = '0; bcd_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  32'(bcd_vld), 0);
        chk("rst_rdy",  32'(bin_rdy), 1);
        chk("rst_bcd",  32'(bcd), 0);
        chk("rst_ovf",  32'(bcd_ovf), 0);
        chk("rst_vld3", 32'(bcd_vld3), 0);
        chk("rst_rdy3", 32'(bin_rdy3), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // single conversion: latency and most negative input
        bin = 11'h400; bin_vld = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            bin_vld = 1'b0;
            n++;
        end while (!bcd_vld && n < 40);
        chk("lat",       n, 12);
        chk("n1024",     32'(bcd), 32'(E4_N1024));
        chk("n1024_ovf", 32'(bcd_ovf), 0);
        chk("n1024_d3",  32'(bcd3), 32'(E3_N1024));
        chk("n1024_o3",  32'(bcd_ovf3), 32'(O3_N1024));
        repeat (2) @(posedge clk); #1;
        q.delete();

        // back-to-back 1023, 0, 11'h7FF
        bin = 11'd1023; bin_vld = 1'b1;
        @(posedge clk); #1; bin = 11'd0;
        @(posedge clk); #1; bin = 11'h7FF;
        @(posedge clk); #1; bin_vld = 1'b0;
        wait_q(3, 40);
        chk("b2b_cnt", q.size(), 3);
        if (q.size() == 3) begin
            chk("b2b_1023",    32'(q[0].b4), 32'h01023);
            chk("b2b_1023_o",  32'(q[0].o4), 0);
            chk("b2b_1023_d3", 32'(q[0].b3), 32'h0999);
            chk("b2b_1023_o3", 32'(q[0].o3), 1);
            chk("b2b_zero",    32'(q[1].b4), 0);
            chk("b2b_zero_d3", 32'(q[1].b3), 0);
            chk("b2b_zero_o3", 32'(q[1].o3), 0);
            chk("b2b_7ff",     32'(q[2].b4), 32'(E4_N1));
            chk("b2b_7ff_o",   32'(q[2].o4), 0);
            chk("b2b_7ff_d3",  32'(q[2].b3), 32'(E3_N1));
            chk("b2b_7ff_o3",  32'(q[2].o3), 32'(O3_N1));
            chk("b2b_seq1",    q[1].cyc - q[0].cyc, 1);
            chk("b2b_seq2",    q[2].cyc - q[1].cyc, 1);
        end
        q.delete();

        // three-digit boundary: 999, 1000, -999 (11'h419)
        bin = 11'd999; bin_vld = 1'b1;
        @(posedge clk); #1; bin = 11'd1000;
        @(posedge clk); #1; bin = 11'h419;
        @(posedge clk); #1; bin_vld = 1'b0;
        wait_q(3, 40);
        chk("d3_cnt", q.size(), 3);
        if (q.size() == 3) begin
            chk("d3_999",     32'(q[0].b3), 32'h0999);
            chk("d3_999_o",   32'(q[0].o3), 0);
            chk("d4_999",     32'(q[0].b4), 32'h00999);
            chk("d3_1000",    32'(q[1].b3), 32'h0999);
            chk("d3_1000_o",  32'(q[1].o3), 1);
            chk("d4_1000",    32'(q[1].b4), 32'h01000);
            chk("d4_1000_o",  32'(q[1].o4), 0);
            chk("d3_n999",    32'(q[2].b3), 32'(E3_N999));
            chk("d3_n999_o",  32'(q[2].o3), 32'(O3_N999));
            chk("d4_n999",    32'(q[2].b4), 32'(E4_N999));
        end
        q.delete();

        // stream of 20 values under random backpressure
        idx = 0; cycles = 0;
        while (q.size() < 20 && cycles < 500) begin
            @(posedge clk); #1;
            bcd_rdy = 1'($urandom_range(0, 1));
            if (idx < 20) begin
                bin = 11'(100 + idx); bin_vld = 1'b1;
            end else begin
                bin_vld = 1'b0;
            end
            @(negedge clk);
            chk("stall_rdy", 32'(bin_rdy), 32'(!(bcd_vld && !bcd_rdy)));
            if (bin_vld && bin_rdy) idx++;
            cycles++;
        end
        @(posedge clk); #1;
        bcd_rdy = 1'b1; bin_vld = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("strm_cnt", q.size(), 20);
        if (q.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                e = m4(100 + i);
                chk("strm_val", 32'(q[i].b4), 32'({1'b0, e}));
                chk("strm_d3",  32'(q[i].b3), 32'({1'b0, e[11:0]}));
            end
        end
        q.delete();

        // reset with five conversions in flight; bin_vld during reset is ignored
        for (int i = 0; i < 5; i++) begin
            bin = 11'(500 + i); bin_vld = 1'b1;
            @(posedge clk); #1;
        end
        bin_vld = 1'b0;
        n = 0;
        while (!bcd_vld && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_seen", 32'(bcd_vld), 1);
        rst = 1'b1; bin = 11'd777; bin_vld = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bin_vld = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_vld", 32'(bcd_vld), 0);
        chk("mid_rdy", 32'(bin_rdy), 1);
        chk("mid_bcd", 32'(bcd), 0);
        chk("mid_ovf", 32'(bcd_ovf), 0);
        repeat (30) @(posedge clk); #1;
        chk("mid_stale", q.size(), 0);

        // pipe still converts after the reset
        bin = 11'd42; bin_vld = 1'b1;
        @(posedge clk); #1; bin_vld = 1'b0;
        wait_q(1, 40);
        chk("post_cnt", q.size(), 1);
        if (q.size() == 1) chk("post_42", 32'(q[0].b4), 32'h00042);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
